// File: rtl/bf_prog_loader.sv
// Streams raw bytes into BF program memory, keeping only the eight opcodes,
// padding the tail with 0x00 through PROG_LEN and checking bracket balance.
module bf_prog_loader #(
    parameter int unsigned PROG_ADDR_WIDTH = 14,
    parameter int unsigned PROG_LEN        = 16383
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PROG_ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]                 mem_wdata,
    output logic                       mem_we,
    output logic                       busy,
    output logic                       done,
    output logic                       prog_valid,
    output logic                       err_unbalanced,
    output logic                       err_overflow,
    output logic [PROG_ADDR_WIDTH-1:0] prog_count
);

    typedef enum logic [1:0] {StIdle, StRecv, StPad} state_e;

    localparam logic [PROG_ADDR_WIDTH-1:0] LastAddr = PROG_ADDR_WIDTH'(PROG_LEN);
    localparam logic [PROG_ADDR_WIDTH-1:0] AddrOne  = 1;
    localparam logic [PROG_ADDR_WIDTH:0]   DepthOne = 1;

    localparam logic [7:0] ChEot   = 8'h04;
    localparam logic [7:0] ChOpen  = 8'h5B;
    localparam logic [7:0] ChClose = 8'h5D;

    state_e                     state;
    logic [PROG_ADDR_WIDTH-1:0] wr_ptr;
    logic [PROG_ADDR_WIDTH:0]   depth;
    logic                       accept;
    logic                       is_op;

    assign accept = in_valid && in_ready;

    always_comb begin
        is_op = 1'b0;
        case (in_data)
            8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_op = 1'b1;
            default: is_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= StIdle;
            wr_ptr         <= '0;
            depth          <= '0;
            in_ready       <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_we         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            prog_valid     <= 1'b0;
            err_unbalanced <= 1'b0;
            err_overflow   <= 1'b0;
            prog_count     <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state          <= StRecv;
                        in_ready       <= 1'b1;
                        busy           <= 1'b1;
                        prog_valid     <= 1'b0;
                        err_unbalanced <= 1'b0;
                        err_overflow   <= 1'b0;
                        prog_count     <= '0;
                        wr_ptr         <= '0;
                        depth          <= '0;
                    end
                end
                StRecv: begin
                    if (accept) begin
                        if (in_data == ChEot) begin
                            // First pad write is issued on the terminator edge itself
                            if (depth != '0) err_unbalanced <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= StPad;
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_ptr;
                            mem_wdata <= 8'h00;
                            if (wr_ptr != LastAddr) wr_ptr <= wr_ptr + AddrOne;
                        end else if (is_op) begin
                            if (wr_ptr == LastAddr) begin
                                err_overflow <= 1'b1;
                            end else begin
                                mem_we     <= 1'b1;
                                mem_addr   <= wr_ptr;
                                mem_wdata  <= in_data;
                                wr_ptr     <= wr_ptr + AddrOne;
                                prog_count <= prog_count + AddrOne;
                                if (in_data == ChOpen) begin
                                    depth <= depth + DepthOne;
                                end else if (in_data == ChClose) begin
                                    if (depth == '0) err_unbalanced <= 1'b1;
                                    else depth <= depth - DepthOne;
                                end
                            end
                        end
                    end
                end
                StPad: begin
                    // mem_we is high throughout PAD, so mem_addr is the last slot written
                    if (mem_addr == LastAddr) begin
                        state      <= StIdle;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        prog_valid <= !err_unbalanced && !err_overflow;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= 8'h00;
                        if (wr_ptr != LastAddr) wr_ptr <= wr_ptr + AddrOne;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_prog_loader.sv
// Bench for bf_prog_loader: per-cycle event-queue model plus literal spot checks.
module tb_bf_prog_loader;

    localparam int LEN = 8;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          prog_valid;
    logic          err_unbalanced;
    logic          err_overflow;
    logic [AW-1:0] prog_count;

    bf_prog_loader #(.PROG_ADDR_WIDTH(AW), .PROG_LEN(LEN)) dut (
        .clk(clk), .resetn(resetn), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .done(done),
        .prog_valid(prog_valid), .err_unbalanced(err_unbalanced),
        .err_overflow(err_overflow), .prog_count(prog_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_op(input logic [7:0] b);
        return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
    endfunction

    // One queue entry per future cycle of expected write/done activity.
    typedef struct {
        bit         we;
        int         addr;
        logic [7:0] data;
        bit         dn;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        cur;
    bit         m_busy, m_recv, m_unb, m_ovf, m_pv;
    int         m_cnt, m_depth;
    logic [7:0] mem_img [0:LEN];

    always @(negedge clk) begin
        if (!resetn) begin
            m_busy = 0; m_recv = 0; m_unb = 0; m_ovf = 0; m_pv = 0;
            m_cnt = 0; m_depth = 0;
            exp_q.delete();
        end
        cur = '{we: 1'b0, addr: 0, data: 8'h00, dn: 1'b0};
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        if (cur.dn) begin
            m_busy = 0;
            m_pv   = !m_unb && !m_ovf;
        end
        if (done) done_cnt++;
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        if (cur.we) begin
            chk("mem_addr", 32'(mem_addr), cur.addr);
            chk("mem_wdata", 32'(mem_wdata), 32'(cur.data));
        end
        if (mem_we && mem_addr <= AW'(LEN)) mem_img[mem_addr] = mem_wdata;
        chk("done", 32'(done), 32'(cur.dn));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("in_ready", 32'(in_ready), 32'(m_recv));
        chk("prog_valid", 32'(prog_valid), 32'(m_pv));
        chk("err_unbalanced", 32'(err_unbalanced), 32'(m_unb));
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        chk("prog_count", 32'(prog_count), m_cnt);

        // Predict what the coming edge does with the inputs now on the pins
        if (resetn) begin
            if (!m_busy && start) begin
                m_busy = 1; m_recv = 1; m_unb = 0; m_ovf = 0; m_pv = 0;
                m_cnt = 0; m_depth = 0;
                for (int i = 0; i <= LEN; i++) mem_img[i] = 8'hEE;
            end else if (m_recv && in_valid) begin
                if (in_data == 8'h04) begin
                    if (m_depth != 0) m_unb = 1;
                    m_recv = 0;
                    for (int a = m_cnt; a <= LEN; a++)
                        exp_q.push_back('{we: 1'b1, addr: a, data: 8'h00, dn: 1'b0});
                    exp_q.push_back('{we: 1'b0, addr: 0, data: 8'h00, dn: 1'b1});
                end else if (is_op(in_data)) begin
                    if (m_cnt < LEN) begin
                        exp_q.push_back('{we: 1'b1, addr: m_cnt, data: in_data, dn: 1'b0});
                        m_cnt++;
                        if (in_data == 8'h5B) m_depth++;
                        else if (in_data == 8'h5D) begin
                            if (m_depth == 0) m_unb = 1;
                            else m_depth--;
                        end
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        acc = 0; n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_str(input string s, input bit gaps, input bit mid_start);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            if (mid_start && i == 2) pulse_start();
            send_byte(s[i]);
        end
    endtask

    task automatic finish_load();
        bit seen;
        seen = 0;
        send_byte(8'h04);
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    int dc_before;

    initial begin
        resetn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_prog_count", 32'(prog_count), 0);

        pulse_start(); send_str("+[+.]", 0, 0); finish_load();
        chk("l1_count", 32'(prog_count), 5);
        chk("l1_valid", 32'(prog_valid), 1);
        chk("l1_m0", 32'(mem_img[0]), 32'h2B);
        chk("l1_m1", 32'(mem_img[1]), 32'h5B);
        chk("l1_m3", 32'(mem_img[3]), 32'h2E);
        chk("l1_m4", 32'(mem_img[4]), 32'h5D);
        chk("l1_m5", 32'(mem_img[5]), 32'h00);
        chk("l1_m8", 32'(mem_img[8]), 32'h00);

        pulse_start(); send_str("a+ b\n", 0, 0); send_byte(8'h00); send_str("-", 0, 0);
        finish_load();
        chk("l2_count", 32'(prog_count), 2);
        chk("l2_m1", 32'(mem_img[1]), 32'h2D);
        chk("l2_m2", 32'(mem_img[2]), 32'h00);

        pulse_start(); send_str("]+[", 0, 0); finish_load();
        chk("l3_unb", 32'(err_unbalanced), 1);
        chk("l3_valid", 32'(prog_valid), 0);
        chk("l3_m0", 32'(mem_img[0]), 32'h5D);
        chk("l3_m2", 32'(mem_img[2]), 32'h5B);

        pulse_start(); send_str("[[]", 0, 0); finish_load();
        chk("l4_unb", 32'(err_unbalanced), 1);
        chk("l4_count", 32'(prog_count), 3);

        pulse_start(); send_str("><+-.,[]", 0, 0); finish_load();
        chk("l5_count", 32'(prog_count), 8);
        chk("l5_valid", 32'(prog_valid), 1);
        chk("l5_m7", 32'(mem_img[7]), 32'h5D);
        chk("l5_m8", 32'(mem_img[8]), 32'h00);

        pulse_start(); send_str("++++++++++", 0, 0); finish_load();
        chk("l6_ovf", 32'(err_overflow), 1);
        chk("l6_count", 32'(prog_count), 8);
        chk("l6_valid", 32'(prog_valid), 0);

        pulse_start(); send_str("+[+.]", 1, 1); finish_load();
        chk("l7_count", 32'(prog_count), 5);
        chk("l7_valid", 32'(prog_valid), 1);
        chk("l7_m4", 32'(mem_img[4]), 32'h5D);

        dc_before = done_cnt;
        pulse_start(); send_byte(8'h2B); send_byte(8'h04);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("rstpad_we", 32'(mem_we), 0);
        chk("rstpad_busy", 32'(busy), 0);
        chk("rstpad_valid", 32'(prog_valid), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("rstpad_no_done", done_cnt, dc_before);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
